// File: rtl/sort_input_arbiter.sv
// Round-robin packet arbiter: merges N_CH Avalon-ST requesters into one stream
// for a shared sort engine, truncating packets longer than MAX_PKT_LEN words.
module sort_input_arbiter #(
   parameter  int DWIDTH      = 10,
   parameter  int N_CH        = 2,
   parameter  int MAX_PKT_LEN = 10,
   localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                        clk_i,
   input  logic                        srst_i,
   input  logic [N_CH-1:0][DWIDTH-1:0] snk_data_i,
   input  logic [N_CH-1:0]             snk_startofpacket_i,
   input  logic [N_CH-1:0]             snk_endofpacket_i,
   input  logic [N_CH-1:0]             snk_valid_i,
   output logic [N_CH-1:0]             snk_ready_o,
   output logic [DWIDTH-1:0]           src_data_o,
   output logic                        src_startofpacket_o,
   output logic                        src_endofpacket_o,
   output logic                        src_valid_o,
   input  logic                        src_ready_i,
   output logic [CH_W-1:0]             src_channel_o,
   output logic                        len_err_o
);

   localparam int               CNT_W    = $clog2(MAX_PKT_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT_LEN - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PKT_LEN);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DROP
   } state_t;

   state_t           state;
   logic [CH_W-1:0]  grant;
   logic [CH_W-1:0]  rr_ptr;
   logic [CNT_W-1:0] beat_cnt;
   logic             first_beat;
   logic             len_err_q;

   logic [N_CH-1:0]  sop_req;
   logic             cand_found;
   logic [CH_W-1:0]  cand_idx;
   logic [CH_W-1:0]  search_idx;
   logic             xfer;
   logic             ch_eop;
   logic             last_beat;

   function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] ch);
      return (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
   endfunction

   assign sop_req   = snk_valid_i & snk_startofpacket_i;
   assign ch_eop    = snk_endofpacket_i[grant];
   assign last_beat = (beat_cnt == LAST_CNT);

   // Cyclic search starting at rr_ptr; the first requester found wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      cand_found = 1'b0;
      cand_idx   = '0;
      search_idx = rr_ptr;
      for (int off = 0; off < N_CH; off++) begin
         if (!cand_found && sop_req[search_idx]) begin
            cand_found = 1'b1;
            cand_idx   = search_idx;
         end
         search_idx = wrap_inc(search_idx);
      end
   end

   always_comb begin
      xfer = 1'b0;
      case (state)
         BUSY:    xfer = snk_valid_i[grant] & src_ready_i;
         DROP:    xfer = snk_valid_i[grant];
         default: xfer = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         state      <= IDLE;
         grant      <= '0;
         rr_ptr     <= '0;
         beat_cnt   <= '0;
         first_beat <= 1'b1;
         len_err_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples pre-edge values.
         len_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (cand_found) begin
                  grant      <= cand_idx;
                  beat_cnt   <= '0;
                  first_beat <= 1'b1;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (xfer) begin
                  first_beat <= 1'b0;
                  if (beat_cnt != FULL_CNT)
                     beat_cnt <= beat_cnt + 1'b1;
                  if (ch_eop) begin
                     rr_ptr <= wrap_inc(grant);
                     state  <= IDLE;
                  end else if (last_beat) begin
                     len_err_q <= 1'b1;
                     rr_ptr    <= wrap_inc(grant);
                     state     <= DROP;
                  end
               end
            end
            DROP: begin
               if (xfer && ch_eop)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data path is purely combinational; reset gates everything to zero.
   always_comb begin
      src_data_o          = '0;
      src_startofpacket_o = 1'b0;
      src_endofpacket_o   = 1'b0;
      src_valid_o         = 1'b0;
      snk_ready_o         = '0;
      if (!srst_i) begin
         case (state)
            IDLE: snk_ready_o = snk_valid_i & ~snk_startofpacket_i;
            BUSY: begin
               src_valid_o        = snk_valid_i[grant];
               snk_ready_o[grant] = src_ready_i;
               if (snk_valid_i[grant]) begin
                  src_data_o          = snk_data_i[grant];
                  src_startofpacket_o = first_beat;
                  src_endofpacket_o   = ch_eop | last_beat;
               end
            end
            DROP:    snk_ready_o[grant] = 1'b1;
            default: snk_ready_o = '0;
         endcase
      end
   end

   assign src_channel_o = grant;
   assign len_err_o     = len_err_q;

   a_len_err_pulse : assert property (@(posedge clk_i) disable iff (srst_i)
      len_err_o |=> !len_err_o);
   a_grant_range : assert property (@(posedge clk_i) disable iff (srst_i)
      int'(grant) < N_CH);
   a_idle_quiet : assert property (@(posedge clk_i) disable iff (srst_i)
      !src_valid_o |-> (src_data_o == '0 && !src_startofpacket_o && !src_endofpacket_o));

endmodule

// File: tb/tb_sort_input_arbiter.sv
// Randomized scoreboard bench for sort_input_arbiter: packet-level round-robin
// reference model feeds an expected-beat queue checked by an independent monitor.
module tb_sort_input_arbiter;

   localparam int DW   = 10;
   localparam int NC   = 3;
   localparam int MAXL = 10;
   localparam int CHW  = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
   } word_t;

   typedef struct packed {
      logic [DW-1:0]  data;
      logic           sop;
      logic           eop;
      logic [CHW-1:0] ch;
      logic           trunc;
   } beat_t;

   logic                   clk_i = 1'b0;
   logic                   srst_i;
   logic [NC-1:0][DW-1:0]  snk_data;
   logic [NC-1:0]          snk_sop, snk_eop, snk_valid, snk_ready;
   logic [DW-1:0]          src_data;
   logic                   src_sop, src_eop, src_valid, src_ready;
   logic [CHW-1:0]         src_channel;
   logic                   len_err;

   sort_input_arbiter #(.DWIDTH(DW), .N_CH(NC), .MAX_PKT_LEN(MAXL)) dut (
      .clk_i               (clk_i),
      .srst_i              (srst_i),
      .snk_data_i          (snk_data),
      .snk_startofpacket_i (snk_sop),
      .snk_endofpacket_i   (snk_eop),
      .snk_valid_i         (snk_valid),
      .snk_ready_o         (snk_ready),
      .src_data_o          (src_data),
      .src_startofpacket_o (src_sop),
      .src_endofpacket_o   (src_eop),
      .src_valid_o         (src_valid),
      .src_ready_i         (src_ready),
      .src_channel_o       (src_channel),
      .len_err_o           (len_err)
   );

   always #5 clk_i = ~clk_i;

   word_t chw [NC][256];
   int    hd [NC];
   int    tl [NC];
   int    pk_start [NC][8];
   int    pk_len [NC][8];
   int    npk [NC];
   beat_t sb[$];
   int    rr_model;
   int    checks = 0;
   int    errors = 0;
   int    ready_mode;
   bit    gap_en;
   bit    tog;
   logic [NC-1:0] acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_round();
      for (int c = 0; c < NC; c++) begin
         hd[c]  = 0;
         tl[c]  = 0;
         npk[c] = 0;
      end
   endtask

   task automatic add_packet(input int c, input int len, input bit mid_sop);
      pk_start[c][npk[c]] = tl[c];
      pk_len[c][npk[c]]   = len;
      npk[c]++;
      for (int i = 0; i < len; i++) begin
         chw[c][tl[c]].data = DW'($urandom);
         chw[c][tl[c]].sop  = (i == 0) || (mid_sop && i == 2) ||
                              (mid_sop && i > 0 && $urandom_range(0, 3) == 0);
         chw[c][tl[c]].eop  = (i == len - 1);
         tl[c]++;
      end
   endtask

   task automatic add_stray(input int c);
      chw[c][tl[c]].data = DW'($urandom);
      chw[c][tl[c]].sop  = 1'b0;
      chw[c][tl[c]].eop  = 1'b0;
      tl[c]++;
   endtask

   // Packet-level round robin: every channel holding packets is requesting
   // whenever the arbiter is free; the next grant is the first such channel
   // at or after the pointer, and the pointer moves past each granted channel.
   task automatic schedule();
      int    rem [NC];
      int    k [NC];
      int    total, pick, len, st, nout;
      beat_t e;
      total = 0;
      for (int c = 0; c < NC; c++) begin
         rem[c] = npk[c];
         k[c]   = 0;
         total += npk[c];
      end
      for (int n = 0; n < total; n++) begin
         pick = -1;
         for (int off = 0; off < NC; off++)
            if (pick < 0 && rem[(rr_model + off) % NC] > 0)
               pick = (rr_model + off) % NC;
         len  = pk_len[pick][k[pick]];
         st   = pk_start[pick][k[pick]];
         nout = (len > MAXL) ? MAXL : len;
         for (int b = 0; b < nout; b++) begin
            e.data  = chw[pick][st + b].data;
            e.sop   = (b == 0);
            e.eop   = (b == nout - 1);
            e.ch    = CHW'(pick);
            e.trunc = (len > MAXL) && (b == nout - 1);
            sb.push_back(e);
         end
         k[pick]++;
         rem[pick]--;
         rr_model = (pick + 1) % NC;
      end
   endtask

   task automatic drive();
      for (int c = 0; c < NC; c++) begin
         if (hd[c] < tl[c]) begin
            snk_data[c]  = chw[c][hd[c]].data;
            snk_sop[c]   = chw[c][hd[c]].sop;
            snk_eop[c]   = chw[c][hd[c]].eop;
            snk_valid[c] = chw[c][hd[c]].sop || !gap_en || ($urandom_range(0, 3) != 0);
         end else begin
            snk_data[c]  = '0;
            snk_sop[c]   = 1'b0;
            snk_eop[c]   = 1'b0;
            snk_valid[c] = 1'b0;
         end
      end
      case (ready_mode)
         0: src_ready = 1'b1;
         1: begin
            src_ready = !tog;
            tog       = !tog;
         end
         default: src_ready = ($urandom_range(0, 9) < 7);
      endcase
   endtask

   function automatic bit all_empty();
      for (int c = 0; c < NC; c++)
         if (hd[c] < tl[c]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock of handshake bookkeeping: sample acceptance mid-cycle, advance after the edge.
   task automatic step();
      @(negedge clk_i);
      acc = snk_valid & snk_ready;
      @(posedge clk_i);
      #1;
      for (int c = 0; c < NC; c++)
         if (acc[c]) hd[c]++;
      drive();
   endtask

   task automatic run_round(input int mode, input bit gaps, input int first_rdy);
      int cyc;
      bit done;
      ready_mode = mode;
      gap_en     = gaps;
      tog        = 1'b0;
      schedule();
      drive();
      cyc  = 0;
      done = 1'b0;
      if (first_rdy >= 0) begin
         @(negedge clk_i);
         check("idle_ready", {29'b0, snk_ready}, first_rdy);
      end
      while (!done) begin
         step();
         cyc++;
         done = all_empty() && (sb.size() == 0);
         if (!done && cyc >= 3000) begin
            check("round_complete", {31'b0, done}, 1);
            sb.delete();
            clear_round();
            drive();
            done = 1'b1;
         end
      end
   endtask

   // Monitor: pops one expected beat per accepted output word.
   initial begin
      beat_t e;
      bit    err_due;
      err_due = 1'b0;
      forever begin
         @(negedge clk_i);
         if (srst_i) begin
            err_due = 1'b0;
         end else begin
            check("len_err", {31'b0, len_err}, {31'b0, err_due});
            err_due = 1'b0;
            if (src_valid && src_ready) begin
               check("beat_expected", {31'b0, sb.size() > 0}, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("data", {22'b0, src_data}, {22'b0, e.data});
                  check("sop", {31'b0, src_sop}, {31'b0, e.sop});
                  check("eop", {31'b0, src_eop}, {31'b0, e.eop});
                  check("channel", {30'b0, src_channel}, {30'b0, e.ch});
                  err_due = e.trunc;
               end
            end else if (!src_valid) begin
               check("idle_zero", {20'b0, src_data, src_sop, src_eop}, 0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_snk_ready"}, {29'b0, snk_ready}, 0);
      check({tag, "_src_out"}, {19'b0, src_data, src_sop, src_eop, src_valid}, 0);
      check({tag, "_chan_err"}, {29'b0, src_channel, len_err}, 0);
   endtask

   initial begin
      int n, tot;
      srst_i     = 1'b1;
      snk_data   = '1;
      snk_sop    = '0;
      snk_eop    = '0;
      snk_valid  = '1;
      src_ready  = 1'b1;
      ready_mode = 0;
      gap_en     = 1'b0;
      rr_model   = 0;
      clear_round();
      #3;
      check_reset_outputs("por");
      repeat (2) @(posedge clk_i);
      #2 srst_i = 1'b0;
      drive();
      @(posedge clk_i);
      #1;

      // ch0 and ch1 start together with pointer 0
      clear_round();
      add_packet(0, 3, 0);
      add_packet(1, 3, 0);
      run_round(0, 0, -1);

      // Both keep offering 4-word packets: grants must alternate
      clear_round();
      for (int i = 0; i < 3; i++) begin
         add_packet(0, 4, 0);
         add_packet(1, 4, 0);
      end
      run_round(0, 0, -1);

      // Toggling backpressure on a 5-word packet
      clear_round();
      add_packet(0, 5, 0);
      run_round(1, 0, -1);

      // 13-word packet on ch1 truncated at 10
      clear_round();
      add_packet(1, 13, 0);
      run_round(0, 0, -1);

      // Exactly MAX words: natural eop, no length error
      clear_round();
      add_packet(2, MAXL, 0);
      run_round(0, 0, -1);

      // Repeated sop mid-packet must not re-flag sop
      clear_round();
      add_packet(2, 6, 1);
      run_round(0, 0, -1);

      // Single-word packet, then immediately IDLE: stray flushed, sop held off
      clear_round();
      add_packet(1, 1, 0);
      run_round(0, 0, -1);
      clear_round();
      add_packet(0, 2, 0);
      add_stray(2);
      run_round(0, 0, 3'b100);

      // Leave the pointer away from 0, then reset mid-packet on beat 2 of 6
      clear_round();
      add_packet(0, 1, 0);
      run_round(0, 0, -1);
      clear_round();
      add_packet(0, 6, 0);
      ready_mode = 0;
      gap_en     = 1'b0;
      schedule();
      drive();
      n = 0;
      while (sb.size() != 5 && n < 50) begin
         step();
         n++;
      end
      check("reset_reached_beat2", sb.size(), 5);
      #2 srst_i = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      sb.delete();
      clear_round();
      drive();
      rr_model = 0;
      @(posedge clk_i);
      #2 srst_i = 1'b0;
      @(posedge clk_i);
      #1;
      clear_round();
      add_packet(0, 3, 0);
      add_packet(1, 3, 0);
      run_round(2, 1, -1);

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         clear_round();
         tot = 0;
         for (int c = 0; c < NC; c++) begin
            n = $urandom_range(0, 2);
            for (int p = 0; p < n; p++)
               add_packet(c, $urandom_range(1, 13), 1'($urandom_range(0, 1)));
            tot += n;
         end
         if (tot == 0)
            add_packet($urandom_range(0, NC - 1), $urandom_range(1, 13), 0);
         run_round($urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
      end

      repeat (3) @(posedge clk_i);
      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sort_input_arbiter.md
SORT_INPUT_ARBITER -- requirements
Module: sort_input_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 10, width of one data word.
REQ-002 SHALL have parameter N_CH, default 2, number of Avalon-ST requester channels (range 2..8).
REQ-003 SHALL have parameter MAX_PKT_LEN, default 10, largest packet the shared sort engine accepts, in words.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port srst_i, input, 1, reset: asynchronous and active-high.
REQ-006 SHALL have port snk_data_i, input, N_CH x DWIDTH, per-channel data.
REQ-007 SHALL have ports snk_startofpacket_i, snk_endofpacket_i and snk_valid_i, input, N_CH each, per-channel Avalon-ST flags.
REQ-008 SHALL have port snk_ready_o, output, N_CH, per-channel ready.
REQ-009 SHALL have ports src_data_o (output, DWIDTH), src_startofpacket_o, src_endofpacket_o and src_valid_o (output, 1 each), the stream to the sort engine.
REQ-010 SHALL have port src_ready_i, input, 1, sort engine ready.
REQ-011 SHALL have port src_channel_o, output, max(1,$clog2(N_CH)), index of the granted channel.
REQ-012 SHALL have port len_err_o, output, 1, one-cycle pulse on packet truncation.

Function
REQ-013 SHALL implement states IDLE, BUSY and DROP; transfer = src_valid_o && src_ready_i in BUSY, or snk_valid_i[grant] && snk_ready_o[grant] in DROP.
REQ-014 IDLE: candidates = channels with snk_valid_i && snk_startofpacket_i; search cyclically from rr_ptr; first candidate loaded into grant; next state BUSY; src_valid_o = 0.
REQ-015 IDLE: channels with snk_valid_i && !snk_startofpacket_i SHALL see snk_ready_o = 1 and their words are discarded (stray-word flush); sop channels see snk_ready_o = 0.
REQ-016 BUSY: src_data_o = snk_data_i[grant], src_valid_o = snk_valid_i[grant], snk_ready_o[grant] = src_ready_i, all other snk_ready_o = 0; combinational path, zero added latency.
REQ-017 BUSY: src_startofpacket_o = 1 only on the first transfer of the packet (first-beat flag), regardless of a repeated sop from the channel mid-packet.
REQ-018 BUSY: src_endofpacket_o = snk_endofpacket_i[grant], or forced to 1 on transfer number MAX_PKT_LEN.
REQ-019 Beat counter, width $clog2(MAX_PKT_LEN+1): cleared entering BUSY, incremented per BUSY transfer, never wraps.
REQ-020 Transfer with channel eop (including a single-word sop+eop packet) SHALL return to IDLE and set rr_ptr = (grant+1) mod N_CH.
REQ-021 Transfer number MAX_PKT_LEN without channel eop SHALL assert len_err_o for the next cycle, set rr_ptr = (grant+1) mod N_CH and go to DROP.
REQ-022 DROP: src_valid_o = 0, snk_ready_o[grant] = 1; words discarded until a transfer with eop, then IDLE.
REQ-023 src_channel_o SHALL equal grant at all times; src outputs other than src_channel_o SHALL be 0 whenever src_valid_o = 0.
REQ-024 Grant SHALL NOT change between the first transfer and the eop or truncating transfer; channel valid deasserting mid-packet holds the grant.

Reset
REQ-025 srst_i SHALL asynchronously force state IDLE, grant 0, rr_ptr 0, beat counter 0 and first-beat flag 1.
REQ-026 During reset, all outputs SHALL be 0.
REQ-027 Reset mid-packet abandons the packet with no eop emitted; first cycle after release is IDLE.

Verification
REQ-028 Arbitration: ch0 and ch1 both present sop in the same cycle, rr_ptr = 0 -> ch0 packet of 3 words passes with src_channel_o = 0; rr_ptr = 1; ch1 then granted.
REQ-029 Fairness: ch0 and ch1 continuously offer 4-word packets -> output alternates 0,1,0,1; no channel is granted twice in a row while the other waits.
REQ-030 Backpressure: src_ready_i toggles 1,0,1,0 during a 5-word packet -> exactly 5 transfers, data order preserved, sop on beat 1 only, eop on beat 5.
REQ-031 Truncation: MAX_PKT_LEN = 10, ch1 sends 13 words with eop on word 13 -> 10 words out, eop forced on word 10, len_err_o single pulse, words 11-13 absorbed in DROP, then IDLE.
REQ-032 Boundaries: single-word sop+eop packet -> one transfer with sop = eop = 1, back to IDLE next cycle; stray word (valid, no sop) in IDLE -> accepted and not forwarded.
REQ-033 Reset: srst_i asserted asynchronously on beat 2 of 6 -> outputs 0 immediately; after release, a new ch0 packet is granted with rr_ptr = 0.
